// File: rtl/hpdcache_demux_ctrl_pkg.sv
// Shared types and helpers for the hpdcache demux credit controller.
package hpdcache_demux_ctrl_pkg;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

    // Counter must hold every value 0..credits inclusive.
    function automatic int cnt_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/hpdcache_credit_counter.sv
// Per-output credit counter: starts full, spends one credit per delivered beat,
// regains one per returned credit, and flags a return that would overflow.
module hpdcache_credit_counter
    import hpdcache_demux_ctrl_pkg::*;
#(
    parameter int CREDITS   = 4,
    parameter int CNT_WIDTH = cnt_width(CREDITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 take,
    input  logic                 give,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow
);

    localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(CREDITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= MAX;
            overflow <= 1'b0;
        end else begin
            case ({give, take})
                2'b10: begin
                    // A return into a full counter is a protocol error; the count holds.
                    if (count == MAX) overflow <= 1'b1;
                    else              count    <= count + CNT_WIDTH'(1);
                end
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hpdcache_demux_ctrl.sv
// Credit-flow router feeding the hpdcache response/refill demux: one-entry slot,
// per-destination credits. HPDCACHE_DEMUX_CTRL_STATS_EN adds per-output stall counters.
module hpdcache_demux_ctrl
    import hpdcache_demux_ctrl_pkg::*;
#(
    parameter int  NOUTPUT    = 4,
    parameter int  DATA_WIDTH = 64,
    parameter int  CREDITS    = 4,
    localparam int DEST_WIDTH = $clog2(NOUTPUT),
    localparam int CNT_WIDTH  = cnt_width(CREDITS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DEST_WIDTH-1:0]         in_dest_i,
    input  logic [DATA_WIDTH-1:0]         in_data_i,
    output logic [NOUTPUT-1:0]            out_valid_o,
    input  logic [NOUTPUT-1:0]            out_ready_i,
    output logic [NOUTPUT*DATA_WIDTH-1:0] out_data_o,
    input  logic [NOUTPUT-1:0]            credit_return_i,
    output logic [NOUTPUT*CNT_WIDTH-1:0]  credits_o,
    output logic                          drop_o,
    output logic                          credit_err_o
`ifdef HPDCACHE_DEMUX_CTRL_STATS_EN
    ,
    output logic [NOUTPUT*32-1:0]         stall_cnt_o
`endif
);

    slot_state_e                          state;
    logic [DEST_WIDTH-1:0]                dest_q;
    logic [DATA_WIDTH-1:0]                data_q;
    logic [NOUTPUT-1:0]                   hit, avail, send_vec, overflow;
    logic [NOUTPUT-1:0][CNT_WIDTH-1:0]    credit;
    logic                                 send, accept, in_range;

    assign send         = |send_vec;
    assign in_ready_o   = (state == SLOT_EMPTY) || send;
    assign accept       = in_valid_i && in_ready_o;
    assign out_valid_o  = hit & avail;
    assign credit_err_o = |overflow;

    // Only a non-power-of-two fan-out can encode a destination that does not exist.
    if ((2 ** DEST_WIDTH) == NOUTPUT) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = {1'b0, in_dest_i} < (DEST_WIDTH + 1)'(NOUTPUT);
    end

    for (genvar i = 0; i < NOUTPUT; i++) begin : g_out
        assign hit[i]      = (state == SLOT_FULL) && (dest_q == DEST_WIDTH'(i));
        assign avail[i]    = credit[i] != '0;
        assign send_vec[i] = hit[i] && avail[i] && out_ready_i[i];
        assign out_data_o[i*DATA_WIDTH +: DATA_WIDTH] = hit[i] ? data_q : '0;
        assign credits_o[i*CNT_WIDTH +: CNT_WIDTH]    = credit[i];

        hpdcache_credit_counter #(
            .CREDITS   (CREDITS),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_credit (
            .clk      (clk_i),
            .rst      (rst_i),
            .take     (send_vec[i]),
            .give     (credit_return_i[i]),
            .count    (credit[i]),
            .overflow (overflow[i])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= SLOT_EMPTY;
            dest_q <= '0;
            data_q <= '0;
            drop_o <= 1'b0;
        end else begin
            drop_o <= accept && !in_range;
            if (accept && in_range) begin
                state  <= SLOT_FULL;
                dest_q <= in_dest_i;
                data_q <= in_data_i;
            end else if (send) begin
                state  <= SLOT_EMPTY;
            end
        end
    end

`ifdef HPDCACHE_DEMUX_CTRL_STATS_EN
    for (genvar i = 0; i < NOUTPUT; i++) begin : g_stall
        logic [31:0] cnt;
        always_ff @(posedge clk_i) begin
            if (rst_i)                         cnt <= '0;
            else if (hit[i] && !send && cnt != '1) cnt <= cnt + 32'd1;
        end
        assign stall_cnt_o[i*32 +: 32] = cnt;
    end
`endif

endmodule

// File: tb/tb_hpdcache_demux_ctrl.sv
// Randomized + directed bench for hpdcache_demux_ctrl: a pending-beat queue and
// per-output outstanding-credit counts predict every output each cycle.
module tb_hpdcache_demux_ctrl;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CR = 4;
    localparam int CW = 3;
    localparam logic [N*CW-1:0] ALL_FULL = {N{3'd4}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0, in_ready;
    logic [1:0]      in_dest = '0;
    logic [DW-1:0]   in_data = '0;
    logic [N-1:0]    out_valid, out_ready = '1, credit_return = '0;
    logic [N*DW-1:0] out_data;
    logic [N*CW-1:0] credits;
    logic            drop, credit_err;

    logic            v3 = 1'b0, r3, drop3, err3;
    logic [1:0]      d3 = '0;
    logic [DW-1:0]   dat3 = '0;
    logic [2:0]      ov3, or3 = '1, cr3 = '0;
    logic [3*DW-1:0] od3;
    logic [3*CW-1:0] c3;

    hpdcache_demux_ctrl #(.NOUTPUT(N), .DATA_WIDTH(DW), .CREDITS(CR)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_dest_i(in_dest), .in_data_i(in_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .credit_return_i(credit_return),
        .credits_o(credits), .drop_o(drop), .credit_err_o(credit_err)
    );

    hpdcache_demux_ctrl #(.NOUTPUT(3), .DATA_WIDTH(DW), .CREDITS(CR)) dut3 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v3), .in_ready_o(r3),
        .in_dest_i(d3), .in_data_i(dat3), .out_valid_o(ov3),
        .out_ready_i(or3), .out_data_o(od3), .credit_return_i(cr3),
        .credits_o(c3), .drop_o(drop3), .credit_err_o(err3)
    );

    typedef struct { int dest; logic [DW-1:0] data; } beat_t;
    beat_t pend[$];
    int    outst[N];
    bit    err_exp;
    int    checks = 0, passes = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: pending beats wait in order, a destination may hold at most
    // CR undelivered-and-unreturned beats, and over-return is a sticky error.
    int          m_fd, m_cred;
    logic [N-1:0] m_ev;
    bit          m_del, m_rdy;
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            foreach (outst[i]) outst[i] = 0;
            err_exp = 1'b0;
        end else begin
            m_ev = '0; m_del = 1'b0; m_fd = 0;
            if (pend.size() > 0) begin
                m_fd   = pend[0].dest;
                m_cred = CR - outst[m_fd];
                if (m_cred > 0) m_ev[m_fd] = 1'b1;
                m_del  = m_ev[m_fd] && out_ready[m_fd];
            end
            m_rdy = (pend.size() == 0) || m_del;
            chk("out_valid", out_valid, m_ev);
            chk("in_ready", in_ready, m_rdy);
            chk("credit_err", credit_err, err_exp);
            chk("drop", drop, 0);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("credits[%0d]", i), credits[i*CW +: CW], CR - outst[i]);
                chk($sformatf("data[%0d]", i), out_data[i*DW +: DW],
                    (pend.size() > 0 && m_fd == i) ? pend[0].data : '0);
            end
            if (m_del) begin
                void'(pend.pop_front());
                outst[m_fd]++;
            end
            for (int i = 0; i < N; i++)
                if (credit_return[i]) begin
                    if (outst[i] > 0) outst[i]--;
                    else              err_exp = 1'b1;
                end
            if (in_valid && m_rdy) pend.push_back('{int'(in_dest), in_data});
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input int d, input logic [DW-1:0] x, output bit ok);
        in_valid = 1'b1; in_dest = d[1:0]; in_data = x; ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1; ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send accepted", ok, 1);
    endtask

    task automatic return_all();
        bit busy;
        busy = 1'b1;
        for (int k = 0; k < 80 && busy; k++) begin
            out_ready = '1;
            for (int i = 0; i < N; i++) credit_return[i] = outst[i] > 0;
            tick();
            busy = pend.size() > 0;
            for (int i = 0; i < N; i++) if (outst[i] > 0) busy = 1'b1;
        end
        credit_return = '0;
        chk("drain", busy, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", |out_data, 0);
        chk("reset credits", credits, ALL_FULL);
        chk("reset drop", drop, 0);
        chk("reset credit_err", credit_err, 0);

        // Out-of-range destination on a 3-output instance
        v3 = 1'b1; d3 = 2'd3; dat3 = 64'hdead;
        #1 chk("oor ready", r3, 1);
        tick(); v3 = 1'b0; #1;
        chk("oor drop pulse", drop3, 1);
        chk("oor no valid", ov3, 0);
        chk("oor slot empty", r3, 1);
        tick(); #1 chk("oor drop once", drop3, 0);
        v3 = 1'b1; d3 = 2'd2; dat3 = 64'h77;
        tick(); v3 = 1'b0; #1;
        chk("n3 valid", ov3, 3'b100);
        chk("n3 data", od3[2*DW +: DW], 64'h77);
        tick(); #1 chk("n3 credit", c3[2*CW +: CW], 3);

        // Single beat to dest 2
        send_beat(2, 64'hA5, ok); #1;
        chk("t1 valid", out_valid, 4'b0100);
        chk("t1 data", out_data[2*DW +: DW], 64'hA5);
        tick(); #1 chk("t1 credit", credits[2*CW +: CW], 3);
        return_all();

        // Credit exhaustion on dest 1
        for (int j = 0; j < 5; j++) send_beat(1, 64'h100 + j, ok);
        in_valid = 1'b1; in_dest = 2'd1; in_data = 64'h105;
        repeat (5) tick();
        #1;
        chk("t2 held valid", out_valid[1], 0);
        chk("t2 held ready", in_ready, 0);
        chk("t2 credits 0", credits[1*CW +: CW], 0);
        credit_return = 4'b0010; tick(); credit_return = '0; #1;
        chk("t2 valid after return", out_valid, 4'b0010);
        chk("t2 ready after return", in_ready, 1);
        tick(); in_valid = 1'b0;
        return_all();

        // Back-pressure on dest 3
        out_ready = 4'b0111;
        send_beat(3, 64'h3333_cafe, ok);
        repeat (10) tick();
        chk("t3 held", out_valid, 4'b1000);
        out_ready = '1; tick(); #1;
        chk("t3 credit", credits[3*CW +: CW], 3);
        chk("t3 single delivery", out_valid, 0);
        return_all();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            in_valid  = $urandom_range(0, 9) < 7;
            in_dest   = 2'($urandom_range(0, 3));
            in_data   = {$urandom, $urandom};
            out_ready = 4'($urandom);
            for (int i = 0; i < N; i++)
                credit_return[i] = (outst[i] > 0) && ($urandom_range(0, 2) == 0);
            tick();
        end
        in_valid = 1'b0;
        return_all();

        // Send and return on dest 0 in the same cycle, then over-return
        send_beat(0, 64'h10, ok);
        send_beat(0, 64'h11, ok);
        tick();
        out_ready = 4'b1110;
        send_beat(0, 64'h12, ok);
        out_ready = '1; credit_return = 4'b0001;
        tick(); credit_return = '0; #1;
        chk("t4 send+return", credits[0 +: CW], 2);
        return_all();
        credit_return = 4'b0001; tick(); credit_return = '0; #1;
        chk("t4 err set", credit_err, 1);
        chk("t4 saturated", credits[0 +: CW], 4);
        repeat (3) tick();
        chk("t4 err sticky", credit_err, 1);

        // Reset while a beat waits on dest 0 with one credit left
        for (int j = 0; j < 3; j++) send_beat(0, 64'h20 + j, ok);
        tick();
        out_ready = 4'b1110;
        send_beat(0, 64'h30, ok);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("t6 valid", out_valid, 0);
        chk("t6 credits", credits, ALL_FULL);
        chk("t6 ready", in_ready, 1);
        chk("t6 err cleared", credit_err, 0);
        out_ready = '1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
